// File: rtl/rr_arbiter_mux_if.sv
// Request/output stream bundle for rr_arbiter_mux: NUM_CH valid/ready request channels in, one registered stream out.
interface rr_arbiter_mux_if #(
    parameter int NUM_CH = 5,
    parameter int DATA_W = 16
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        req_last;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        grant;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic                     out_ready;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, grant, out_valid, out_data, out_last
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, grant, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rr_arbiter_mux.sv
// Round-robin arbiter/mux, NUM_CH streams onto one output register; 1-cycle latency, full throughput, req_ready drops while the held flit is stalled.
// ARB_PKT_LOCK_EN: grant stays with a channel until its tail flit (req_last) is accepted.
module rr_arbiter_mux #(
    parameter int NUM_CH = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    rr_arbiter_mux_if.slave   bus,
    output logic              idle
);
    localparam int PTR_W = $clog2(NUM_CH);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt, owner, owner_nxt;
    logic [PTR_W-1:0]   hi_idx, lo_idx, sel_idx, ptr_after;
    logic               hi_found, lo_found, found;
    logic [NUM_CH-1:0]  eligible, sel;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_last, can_load, accept;
    logic               out_valid_q, out_last_q;
    logic [DATA_W-1:0]  out_data_q;

    assign can_load = ~out_valid_q | bus.out_ready;

    // Scan ptr..NUM_CH-1 first, then wrap to 0..ptr-1.
    always_comb begin
        eligible = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = bus.req_valid[i] & ((state == IDLE) | (owner == PTR_W'(i)));
            if (eligible[i] && !hi_found && (PTR_W'(i) >= ptr)) begin
                hi_found = 1'b1;
                hi_idx   = PTR_W'(i);
            end
            if (eligible[i] && !lo_found && (PTR_W'(i) < ptr)) begin
                lo_found = 1'b1;
                lo_idx   = PTR_W'(i);
            end
        end
        found   = hi_found | lo_found;
        sel_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel      = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i] = found & (sel_idx == PTR_W'(i));
            if (sel[i]) begin
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
                sel_last = bus.req_last[i];
            end
        end
    end

    assign accept        = found & can_load;
    assign bus.req_ready = sel & {NUM_CH{can_load}};
    assign bus.grant     = bus.req_ready & bus.req_valid;
    assign ptr_after     = (sel_idx == PTR_W'(NUM_CH - 1)) ? '0 : sel_idx + 1'b1;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
`ifdef ARB_PKT_LOCK_EN
        if (accept) begin
            if (sel_last) begin
                state_nxt = IDLE;
                ptr_nxt   = ptr_after;
            end else begin
                state_nxt = LOCKED;
                owner_nxt = sel_idx;
            end
        end
`else
        state_nxt = IDLE;
        if (accept) begin
            ptr_nxt = ptr_after;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Load and drain in the same cycle simply overwrites the held flit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_last_q  <= sel_last;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign idle          = ~out_valid_q & ~|bus.req_valid & (state == IDLE);
endmodule

// File: doc/rr_arbiter_mux.md
# rr_arbiter_mux

Parametrised round-robin arbiter and data multiplexer that merges NUM_CH valid/ready request streams onto one registered output stream. It is the successor of the fixed 5-channel priority arbiter-mux in the router datapath. It adds generic channel count and data width, per-channel backpressure, a registered output stage with full throughput, and optional packet-locked grants. It sits between the input-port buffers and the crossbar output link.

## Interface
- NUM_CH, 5, number of request channels (legal range 2..16)
- DATA_W, 16, payload width per channel
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- req_valid  input  NUM_CH  per-channel flit valid
- req_data  input  NUM_CH*DATA_W  channel i in bits [i*DATA_W +: DATA_W]
- req_last  input  NUM_CH  per-channel tail-flit marker
- req_ready  output  NUM_CH  per-channel accept; combinational
- grant  output  NUM_CH  one-hot channel accepted this cycle (req_valid & req_ready); all zero if none
- out_valid  output  1  output register holds a flit
- out_data  output  DATA_W  registered payload
- out_last  output  1  registered tail marker
- out_ready  input  1  downstream accept
- idle  output  1  ~out_valid & ~|req_valid & state==IDLE

## Operation
- State: ptr (clog2(NUM_CH) bits, reset 0), state {IDLE, LOCKED} (reset IDLE), owner (reset 0), output register.
- The output stage can load when `can_load = ~out_valid | out_ready`.
- Eligible set:
  - In IDLE, all channels with req_valid.
  - In LOCKED, only owner, if req_valid[owner].
- Selection: the first eligible channel scanning ptr, ptr+1, ... NUM_CH-1, 0, ... ptr-1. At most one channel is selected.
- req_ready[i] = selected[i] & can_load. A channel that is not selected sees req_ready=0, whether or not it is valid.
- On accept from channel i:
  - out_data <= req_data[i]; out_last <= req_last[i]; out_valid <= 1.
- When out_valid & out_ready and there is no accept: out_valid <= 0. out_data and out_last hold their values.
- Pointer update on accept from i: ptr <= (i == NUM_CH-1) ? 0 : i+1. This is the wrap-around case. With the lock feature, ptr updates only on accept of the last flit.
- Simultaneous drain and load in the same cycle: the new flit replaces the old one, out_valid stays 1, and throughput is 1 flit/cycle.
- req_valid dropping without an accept is legal and has no state effect. A channel keeps priority until it is served.
- An asserted reset at any time clears all state immediately. A flit held in the output register is discarded. A locked packet is abandoned, and the lock returns to IDLE.

## Timing
- Latency: input accept in cycle N gives out_valid=1 with that data in cycle N+1.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, ptr=0, state=IDLE, owner=0.
  - grant=0, req_ready=0.
  - idle=1 provided req_valid=0.
- req_ready and grant are combinational from req_valid, state, ptr, out_valid and out_ready. Paths from out_ready to req_ready are permitted.
- Fairness: with all NUM_CH channels continuously valid and out_ready=1, each channel is granted exactly once every NUM_CH cycles.

## Configuration
- Macro ARB_PKT_LOCK_EN.
- Defined:
  - An accept with req_last=0 moves state to LOCKED, sets owner=i, and leaves ptr unchanged.
  - In LOCKED, only owner can be granted.
  - An accept with req_last=1 returns state to IDLE and updates ptr. A single-flit packet (last=1) never enters LOCKED.
- Undefined:
  - State stays IDLE permanently and every flit is arbitrated independently.
  - ptr updates on every accept.
  - req_last is passed through to out_last only.

## Test plan
- Reset mid-operation: out_valid=1 holding 0x1234, reset pulse -> out_valid=0, out_data=0 the same cycle; the first grant after reset goes to the lowest-index valid channel.
- All 5 channels valid, out_ready=1 continuously, data=channel index -> out_data sequence 0,1,2,3,4,0,... one per cycle; grant one-hot rotating.
- Backpressure: out_ready=0 with flit 0xAAAA held -> req_ready all 0, out_data stays 0xAAAA; out_ready=1 -> next flit loads the same cycle, no bubble.
- Wrap: ptr=4 after channel 3 served, channels 0 and 4 valid -> channel 4 granted, then channel 0.
- ARB_PKT_LOCK_EN: channel 1 sends a 3-flit packet (last on the 3rd) while channel 2 is valid throughout -> output 1,1,1,2; grant[2]=0 until channel 1's tail is accepted. Without the macro: output 1,2,1,2,1.
- idle: no requests and output drained -> idle=1; req_valid[3]=1 -> idle=0 the same cycle.
